patch_control_unit: RTL
=======================

# patch_control_unit

Runtime patch engine for the control and observe points tagged in instrumented SoC modules. It is configured over a byte-wide valid/ready stream and watches the tagged observe signals for a programmed match pattern. Once that pattern has persisted for a programmed number of cycles, it overrides selected control signals with programmed values. It sits between the instrumented logic and the patch configuration port: tagged control nets are routed through `ctl_in`→`ctl_out`, and tagged observe nets are fanned into `obs_in`.

## Interface
- `OBS_W`, default 4: number of observe bits; legal range 1..8.
- `CTL_W`, default 4: number of control bits; legal range 1..8.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cfg_valid`, in, 1: configuration byte valid.
- `cfg_data`, in, 8: configuration byte.
- `cfg_ready`, out, 1: unit accepts a byte this cycle.
- `obs_in`, in, `OBS_W`: observed signals.
- `ctl_in`, in, `CTL_W`: original (unpatched) control signals.
- `ctl_out`, out, `CTL_W`: patched control signals.
- `patch_active`, out, 1: high while the override is applied (state FIRED).

## Operation
- **Byte transfer:** a byte transfers on a rising edge where `cfg_valid && cfg_ready`.
- **Loader FSM states:** L_HDR, L_FIELD, L_COMMIT.
  - In L_HDR, byte 0xA5 moves to L_FIELD with the field index set to 0.
  - In L_HDR, byte 0x5A is the disarm command: the trigger FSM goes to DISARMED and the loader stays in L_HDR.
  - In L_HDR, any other byte is accepted and discarded.
- **Field order in L_FIELD:** the five bytes load a shadow register set in this order:
  - `obs_mask`
  - `obs_val`
  - `hold`
  - `ctl_mask`
  - `ctl_val`
- **Field width:** only the low `OBS_W` / `CTL_W` bits of each mask/value byte are kept. `hold` is the full 8 bits.
- **Commit:** after the 5th field the loader enters L_COMMIT for exactly one cycle with `cfg_ready`=0.
  - The shadow set is copied to the active set.
  - The trigger FSM is forced to ARMED, or to DISARMED if `ctl_mask`==0.
  - The hold counter is cleared.
  - The loader returns to L_HDR.
- **Mid-load behaviour:** a partial load has no effect on the active set or on the trigger FSM. A re-sent 0xA5 during L_FIELD is treated as field data, not as a new header.
- **Match:** `match = ((obs_in ^ obs_val) & obs_mask) == 0`. With `obs_mask`==0, `match` is always true.
- **Trigger FSM states:** DISARMED, ARMED, COUNTING, FIRED. The hold counter `cnt` is 8 bits.
  - **DISARMED:** stays until a commit.
  - **ARMED:** if `match` and `hold`==0, go to FIRED. If `match` and `hold`>0, go to COUNTING with `cnt`=1. Otherwise stay.
  - **COUNTING:** if `!match`, go to ARMED with `cnt`=0. If `match` and `cnt`==`hold`, go to FIRED. If `match` otherwise, `cnt`+1.
  - **FIRED:** sticky. It leaves only on a commit (to ARMED/DISARMED), on a disarm command (to DISARMED), or on `rst`.
- **Firing condition:** the unit fires after `hold`+1 consecutive matching edges.
- **Output:** `ctl_out = FIRED ? (ctl_in & ~ctl_mask) | (ctl_val & ctl_mask) : ctl_in`.
  - This is combinational from `ctl_in` and registered state.
  - Unmasked bits always pass through.
- **Simultaneous events:** a commit or disarm takes priority over the trigger FSM's own transition on the same edge.

## Timing
- **Reset values:**
  - Loader in L_HDR; `cfg_ready`=1 after reset.
  - Trigger FSM in DISARMED; `cnt`=0.
  - All active and shadow registers are 0.
  - `patch_active`=0; `ctl_out`=`ctl_in`.
- **Throughput:** `cfg_ready` is 1 in every cycle except L_COMMIT. A full configuration therefore takes 6 accepted bytes plus 1 stall cycle.
- **Commit timing:** the 5th field byte is accepted at edge N, L_COMMIT holds during cycle N+1, and the commit takes effect at edge N+1. `obs_in` is first evaluated against the new set at edge N+2.
- **Disarm timing:** a disarm byte accepted at edge N drops the override in cycle N+1.
- **Fire latency:** if the final required match is sampled at edge N, then `patch_active`=1 and `ctl_out` is overridden from cycle N+1 (one-cycle latency).
- **Counter range:** with `hold`=255 the unit requires 256 consecutive matches. `cnt` never exceeds `hold`, so no wrap can occur.
- **Asynchronous reset mid-operation:** asserting `rst` mid-load or while FIRED immediately returns all outputs to their reset values, without waiting for a clock edge.

## Test plan
- **Reset/bypass:** assert `rst`, drive `ctl_in`=4'b1010 → `ctl_out`=4'b1010, `patch_active`=0, `cfg_ready`=1 after release.
- **Immediate fire:** load A5,03,01,00,0F,05, drive `obs_in`=4'b0001 → `patch_active`=1 one cycle after the first matching edge, and `ctl_out`=4'b0101 for any `ctl_in`.
- **Hold/glitch:** load `hold`=3, `obs_mask`=1, `obs_val`=1, `ctl_mask`=4'b0001, `ctl_val`=0.
  - Drive a match for 3 edges, one mismatch, then a match for 4 edges → fires only after the 4th edge of the second run.
  - With `ctl_in`=4'b1111, `ctl_out`=4'b1110.
- **Config handshake:**
  - Junk bytes 0x00 and 0x77 before A5 are ignored.
  - `cfg_ready`=0 for exactly one cycle after the 5th field byte.
  - A byte held valid during that cycle is accepted on the next edge.
- **Disarm/re-arm:**
  - While FIRED, send 5A → `ctl_out`=`ctl_in` on the next cycle.
  - Reload with `ctl_mask`=0 → stays DISARMED even when `obs_in` matches.
- **Async reset mid-load:** pulse `rst` after 3 field bytes, then send 2 bytes → no commit, state DISARMED, `patch_active`=0.

Source files
------------

// File: rtl/patch_control_unit.sv
// rtl/patch_control_unit.sv - runtime patch engine: byte-stream configured observe-match trigger with control override
module patch_control_unit #(
   parameter int OBS_W = 4,
   parameter int CTL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   input  logic [7:0]       cfg_data,
   output logic             cfg_ready,
   input  logic [OBS_W-1:0] obs_in,
   input  logic [CTL_W-1:0] ctl_in,
   output logic [CTL_W-1:0] ctl_out,
   output logic             patch_active
);

   localparam logic [7:0] HDR_LOAD   = 8'hA5;
   localparam logic [7:0] HDR_DISARM = 8'h5A;

   typedef enum logic [1:0] {L_HDR, L_FIELD, L_COMMIT} ld_state_t;
   typedef enum logic [1:0] {T_DISARMED, T_ARMED, T_COUNTING, T_FIRED} tr_state_t;

   ld_state_t        ld_state, ld_next;
   tr_state_t        tr_state, tr_next;
   logic [2:0]       fidx, fidx_next;
   logic [7:0]       cnt, cnt_next;

   // shadow set, filled field by field while loading
   logic [OBS_W-1:0] sh_obs_mask, sh_obs_mask_next;
   logic [OBS_W-1:0] sh_obs_val, sh_obs_val_next;
   logic [7:0]       sh_hold, sh_hold_next;
   logic [CTL_W-1:0] sh_ctl_mask, sh_ctl_mask_next;
   logic [CTL_W-1:0] sh_ctl_val, sh_ctl_val_next;

   // active set, only ever replaced as a whole on commit
   logic [OBS_W-1:0] act_obs_mask, act_obs_mask_next;
   logic [OBS_W-1:0] act_obs_val, act_obs_val_next;
   logic [7:0]       act_hold, act_hold_next;
   logic [CTL_W-1:0] act_ctl_mask, act_ctl_mask_next;
   logic [CTL_W-1:0] act_ctl_val, act_ctl_val_next;

   logic             xfer;
   logic             match;

   // State and configuration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_state     <= L_HDR;
         tr_state     <= T_DISARMED;
         fidx         <= 3'd0;
         cnt          <= 8'd0;
         sh_obs_mask  <= '0;
         sh_obs_val   <= '0;
         sh_hold      <= 8'd0;
         sh_ctl_mask  <= '0;
         sh_ctl_val   <= '0;
         act_obs_mask <= '0;
         act_obs_val  <= '0;
         act_hold     <= 8'd0;
         act_ctl_mask <= '0;
         act_ctl_val  <= '0;
      end else begin
         ld_state     <= ld_next;
         tr_state     <= tr_next;
         fidx         <= fidx_next;
         cnt          <= cnt_next;
         sh_obs_mask  <= sh_obs_mask_next;
         sh_obs_val   <= sh_obs_val_next;
         sh_hold      <= sh_hold_next;
         sh_ctl_mask  <= sh_ctl_mask_next;
         sh_ctl_val   <= sh_ctl_val_next;
         act_obs_mask <= act_obs_mask_next;
         act_obs_val  <= act_obs_val_next;
         act_hold     <= act_hold_next;
         act_ctl_mask <= act_ctl_mask_next;
         act_ctl_val  <= act_ctl_val_next;
      end
   end

   assign cfg_ready = (ld_state != L_COMMIT);
   assign xfer      = cfg_valid && cfg_ready;
   assign match     = (((obs_in ^ act_obs_val) & act_obs_mask) == '0);

   // Next-state: trigger evaluates first, then loader commit/disarm overrides it
   always_comb begin
      ld_next           = ld_state;
      tr_next           = tr_state;
      fidx_next         = fidx;
      cnt_next          = cnt;
      sh_obs_mask_next  = sh_obs_mask;
      sh_obs_val_next   = sh_obs_val;
      sh_hold_next      = sh_hold;
      sh_ctl_mask_next  = sh_ctl_mask;
      sh_ctl_val_next   = sh_ctl_val;
      act_obs_mask_next = act_obs_mask;
      act_obs_val_next  = act_obs_val;
      act_hold_next     = act_hold;
      act_ctl_mask_next = act_ctl_mask;
      act_ctl_val_next  = act_ctl_val;

      // cnt counts matches already seen in the current run, so it tops out at hold
      case (tr_state)
         T_ARMED: begin
            if (match) begin
               if (act_hold == 8'd0) begin
                  tr_next = T_FIRED;
               end else begin
                  tr_next  = T_COUNTING;
                  cnt_next = 8'd1;
               end
            end
         end
         T_COUNTING: begin
            if (!match) begin
               tr_next  = T_ARMED;
               cnt_next = 8'd0;
            end else if (cnt == act_hold) begin
               tr_next = T_FIRED;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         default: ;
      endcase

      case (ld_state)
         L_HDR: begin
            if (xfer) begin
               if (cfg_data == HDR_LOAD) begin
                  ld_next   = L_FIELD;
                  fidx_next = 3'd0;
               end else if (cfg_data == HDR_DISARM) begin
                  tr_next  = T_DISARMED;
                  cnt_next = 8'd0;
               end
            end
         end
         L_FIELD: begin
            // every byte here is field data, including a repeated header value
            if (xfer) begin
               case (fidx)
                  3'd0:    sh_obs_mask_next = cfg_data[OBS_W-1:0];
                  3'd1:    sh_obs_val_next  = cfg_data[OBS_W-1:0];
                  3'd2:    sh_hold_next     = cfg_data;
                  3'd3:    sh_ctl_mask_next = cfg_data[CTL_W-1:0];
                  default: sh_ctl_val_next  = cfg_data[CTL_W-1:0];
               endcase
               if (fidx == 3'd4) begin
                  ld_next = L_COMMIT;
               end else begin
                  fidx_next = fidx + 3'd1;
               end
            end
         end
         L_COMMIT: begin
            act_obs_mask_next = sh_obs_mask;
            act_obs_val_next  = sh_obs_val;
            act_hold_next     = sh_hold;
            act_ctl_mask_next = sh_ctl_mask;
            act_ctl_val_next  = sh_ctl_val;
            tr_next           = (sh_ctl_mask == '0) ? T_DISARMED : T_ARMED;
            cnt_next          = 8'd0;
            ld_next           = L_HDR;
         end
         default: ld_next = L_HDR;
      endcase
   end

   assign patch_active = (tr_state == T_FIRED);
   assign ctl_out      = patch_active ? ((ctl_in & ~act_ctl_mask) | (act_ctl_val & act_ctl_mask)) : ctl_in;

endmodule
